// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, registers ROM output into IF/ID,
// and handles stall / flush / redirect from later stages.
// A misaligned redirect target parks the stage in HALT until reset.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   input  logic [31:0] inst_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc4_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o,
   output logic        misalign_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {RUN, HALT} state_t;

   // IF/ID pipeline register contents
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic        valid;
   } ifid_t;

   state_t      state;
   logic [31:0] pc;
   ifid_t       ifid;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;

   // PC is a register, so the ROM address never sees a combinational input path
   assign pc_o       = pc;
   assign id_pc_o    = ifid.pc;
   assign id_pc4_o   = ifid.pc4;
   assign id_inst_o  = ifid.inst;
   assign id_valid_o = ifid.valid;

   // Fetch FSM: PC, IF/ID register and sticky misalign flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         ifid       <= '{pc: 32'd0, pc4: 32'd0, inst: NOP, valid: 1'b0};
         misalign_o <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (redirect_i && (redirect_pc_i[1:0] == 2'b00)) begin
                  // redirect wins over stall and flush; one bubble follows
                  pc         <= redirect_pc_i;
                  ifid.valid <= 1'b0;
               end else if (redirect_i) begin
                  // bad target: freeze the front end until reset
                  misalign_o <= 1'b1;
                  ifid.valid <= 1'b0;
                  state      <= HALT;
               end else if (stall_i) begin
                  if (flush_i) ifid.valid <= 1'b0;
               end else begin
                  ifid.pc    <= pc;
                  ifid.pc4   <= pc_plus4;
                  ifid.inst  <= inst_i;
                  ifid.valid <= !flush_i;
                  pc         <= pc_plus4;
               end
            end
            default: begin
               ifid.valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   // Fetch and stall-cycle counters, counted only while running
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_o <= 32'd0;
         stall_cnt_o <= 32'd0;
      end else if (state == RUN && !redirect_i) begin
         if (stall_i) stall_cnt_o <= stall_cnt_o + 32'd1;
         else if (!flush_i) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
   end
`endif

endmodule
